// File: rtl/uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// uart_mmio_ctrl
//   Memory-mapped bridge between the CPU load/store stage and the on-chip
//   UART. Sequences the TX/RX handshakes, buffers received bytes, and exposes
//   a status word plus cycle / retired-instruction counters. Loads return one
//   cycle after the strobe, matching the synchronous data memories.
//
//   Build option:
//     UART_RX_FIFO_EN  defined   -> RX buffer is an RX_FIFO_DEPTH-entry FIFO
//                      undefined -> RX buffer is a single holding register
//   Register map and read latency are identical in both builds.
// ---------------------------------------------------------------------------
module uart_mmio_ctrl #(
    parameter int unsigned RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_en,
    input  logic [3:0]  mmio_we,
    input  logic [7:0]  mmio_addr,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retire,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready
);

    // Register offsets within the MMIO window
    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_RXDATA  = 8'h04;
    localparam logic [7:0] ADDR_TXDATA  = 8'h08;
    localparam logic [7:0] ADDR_CYCLE   = 8'h10;
    localparam logic [7:0] ADDR_INST    = 8'h14;
    localparam logic [7:0] ADDR_CNT_RST = 8'h18;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_e;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic read_s;
    logic write_s;
    logic tx_wr_s;
    logic cnt_rst_s;
    logic pop_s;
    logic push_s;
    logic rx_avail_s;
    logic rx_full_s;
    logic [7:0] rx_head_s;
    logic tx_ready_s;

    assign read_s    = mmio_en && (mmio_we == 4'b0000);
    assign write_s   = mmio_en && (mmio_we != 4'b0000);
    assign tx_wr_s   = write_s && (mmio_addr == ADDR_TXDATA) && mmio_we[0];
    assign cnt_rst_s = write_s && (mmio_addr == ADDR_CNT_RST);
    assign pop_s     = read_s && (mmio_addr == ADDR_RXDATA) && rx_avail_s;
    assign push_s    = uart_rx_data_out_valid && uart_rx_data_out_ready;

    // Upper store-data bits and the depth parameter are not needed by every build
    logic unused_ok_s;
    assign unused_ok_s = ^{mmio_wdata[31:8], 32'(RX_FIFO_DEPTH)};

    // ------------------------------------------------------------------
    // RX ready enable: held low in reset, high from the first cycle after
    // ------------------------------------------------------------------
    logic rx_en_q;

    // Arms the RX handshake once reset has been released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_en_q <= 1'b0;
        end else begin
            rx_en_q <= 1'b1;
        end
    end

    // A full buffer can still take a byte in the cycle its head is popped
    assign uart_rx_data_out_ready = rx_en_q && (!rx_full_s || pop_s);

`ifdef UART_RX_FIFO_EN
    // ------------------------------------------------------------------
    // RX buffer: circular FIFO with wrapping pointers and occupancy count
    // ------------------------------------------------------------------
    localparam int unsigned PTR_W = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(RX_FIFO_DEPTH);

    logic [7:0]       fifo_mem_q [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    assign rx_head_s  = fifo_mem_q[rd_ptr_q];
    assign rx_avail_s = (count_q != '0);
    assign rx_full_s  = (count_q == DEPTH_C);

    // Next pointer / occupancy; push and pop together leave the count unchanged
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: writes the accepted RX byte at the write pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= uart_rx_data_out;
        end
    end
`else
    // ------------------------------------------------------------------
    // RX buffer: single holding register with full flag
    // ------------------------------------------------------------------
    logic [7:0] hold_q;
    logic [7:0] hold_d;
    logic       full_q;
    logic       full_d;

    assign rx_head_s  = hold_q;
    assign rx_avail_s = full_q;
    assign rx_full_s  = full_q;

    // A push (possibly alongside a pop) refills the slot; a lone pop empties it
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (push_s) begin
            hold_d = uart_rx_data_out;
            full_d = 1'b1;
        end else if (pop_s) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Holding register and its full flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= 8'h00;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // TX handshake FSM
    // ------------------------------------------------------------------
    tx_state_e  tx_state_q;
    tx_state_e  tx_state_d;
    logic [7:0] tx_byte_q;
    logic [7:0] tx_byte_d;

    assign tx_ready_s            = (tx_state_q == TX_IDLE);
    assign uart_tx_data_in_valid = (tx_state_q == TX_PEND);
    assign uart_tx_data_in       = tx_byte_q;

    // Next TX state: latch a byte when idle, hold it until the UART takes it
    always_comb begin
        tx_state_d = tx_state_q;
        tx_byte_d  = tx_byte_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_wr_s) begin
                    tx_byte_d  = mmio_wdata[7:0];
                    tx_state_d = TX_PEND;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_PEND: begin
                // Stores to TXDATA here are dropped; the pending byte is kept
                if (uart_tx_data_in_ready) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_state_d = TX_PEND;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // TX state and byte registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_byte_q  <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [31:0] inst_cnt_q;
    logic [31:0] inst_cnt_d;

    // Counter next values; a clear takes priority over the same-cycle increment
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        inst_cnt_d  = inst_cnt_q;
        if (cnt_rst_s) begin
            cycle_cnt_d = 32'h0000_0000;
            inst_cnt_d  = 32'h0000_0000;
        end else begin
            cycle_cnt_d = cycle_cnt_q + 32'h0000_0001;
            if (inst_retire) begin
                inst_cnt_d = inst_cnt_q + 32'h0000_0001;
            end else begin
                inst_cnt_d = inst_cnt_q;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q <= 32'h0000_0000;
            inst_cnt_q  <= 32'h0000_0000;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read data path: one-cycle registered load data, held between reads
    // ------------------------------------------------------------------
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    assign mmio_rdata = rdata_q;

    // Select load data; write-only and unmapped offsets read as zero
    always_comb begin
        rdata_d = rdata_q;
        if (read_s) begin
            case (mmio_addr)
                ADDR_STATUS: rdata_d = {30'h0000_0000, rx_avail_s, tx_ready_s};
                ADDR_RXDATA: begin
                    if (rx_avail_s) begin
                        rdata_d = {24'h00_0000, rx_head_s};
                    end else begin
                        rdata_d = 32'h0000_0000;
                    end
                end
                ADDR_CYCLE:  rdata_d = cycle_cnt_q;
                ADDR_INST:   rdata_d = inst_cnt_q;
                default:     rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Load data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'h0000_0000;
        end else begin
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed testbench for uart_mmio_ctrl. Inputs change and outputs are
// sampled on the falling clock edge; the design acts on the rising edge.
module tb_uart_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmio_en;
    logic [3:0]  mmio_we;
    logic [7:0]  mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        inst_retire;
    logic [7:0]  uart_rx_data_out;
    logic        uart_rx_data_out_valid;
    logic        uart_rx_data_out_ready;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid;
    logic        uart_tx_data_in_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    uart_mmio_ctrl #(.RX_FIFO_DEPTH(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .mmio_en                (mmio_en),
        .mmio_we                (mmio_we),
        .mmio_addr              (mmio_addr),
        .mmio_wdata             (mmio_wdata),
        .mmio_rdata             (mmio_rdata),
        .inst_retire            (inst_retire),
        .uart_rx_data_out       (uart_rx_data_out),
        .uart_rx_data_out_valid (uart_rx_data_out_valid),
        .uart_rx_data_out_ready (uart_rx_data_out_ready),
        .uart_tx_data_in        (uart_tx_data_in),
        .uart_tx_data_in_valid  (uart_tx_data_in_valid),
        .uart_tx_data_in_ready  (uart_tx_data_in_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single-cycle load; returns the registered load data
    task automatic rd(input logic [7:0] addr, output logic [31:0] data);
        mmio_en   = 1'b1;
        mmio_we   = 4'b0000;
        mmio_addr = addr;
        @(negedge clk);
        mmio_en   = 1'b0;
        data      = mmio_rdata;
    endtask

    // Single-cycle store
    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] we);
        mmio_en    = 1'b1;
        mmio_we    = we;
        mmio_addr  = addr;
        mmio_wdata = data;
        @(negedge clk);
        mmio_en    = 1'b0;
        mmio_we    = 4'b0000;
    endtask

    initial begin
        rst                    = 1'b0;
        mmio_en                = 1'b0;
        mmio_we                = 4'b0000;
        mmio_addr              = 8'h00;
        mmio_wdata             = 32'h0000_0000;
        inst_retire            = 1'b0;
        uart_rx_data_out       = 8'h00;
        uart_rx_data_out_valid = 1'b0;
        uart_tx_data_in_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdata",    mmio_rdata, 32'h0000_0000);
        chk("rst_txvalid",  {31'h0, uart_tx_data_in_valid}, 32'h0000_0000);
        chk("rst_txbyte",   {24'h0, uart_tx_data_in}, 32'h0000_0000);
        chk("rst_rxready",  {31'h0, uart_rx_data_out_ready}, 32'h0000_0000);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rxready", {31'h0, uart_rx_data_out_ready}, 32'h0000_0001);
        rd(8'h00, rd_val);
        chk("status_idle", rd_val, 32'h0000_0001);

        // TX: byte held while the UART stalls; second store dropped
        wr(8'h08, 32'h0000_0041, 4'b0001);
        chk("tx_c1_valid", {31'h0, uart_tx_data_in_valid}, 32'h0000_0001);
        chk("tx_c1_byte",  {24'h0, uart_tx_data_in}, 32'h0000_0041);
        wr(8'h08, 32'h0000_0042, 4'b0001);
        chk("tx_c2_valid", {31'h0, uart_tx_data_in_valid}, 32'h0000_0001);
        chk("tx_c2_byte",  {24'h0, uart_tx_data_in}, 32'h0000_0041);
        rd(8'h00, rd_val);
        chk("status_pend", rd_val, 32'h0000_0000);
        chk("tx_c3_valid", {31'h0, uart_tx_data_in_valid}, 32'h0000_0001);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("tx_hold_valid", {31'h0, uart_tx_data_in_valid}, 32'h0000_0001);
            chk("tx_hold_byte",  {24'h0, uart_tx_data_in}, 32'h0000_0041);
        end
        uart_tx_data_in_ready = 1'b1;
        @(negedge clk);
        uart_tx_data_in_ready = 1'b0;
        chk("tx_done_valid", {31'h0, uart_tx_data_in_valid}, 32'h0000_0000);
        rd(8'h00, rd_val);
        chk("status_tx_done", rd_val, 32'h0000_0001);
        wr(8'h08, 32'h0000_0099, 4'b0010);
        chk("tx_no_we0", {31'h0, uart_tx_data_in_valid}, 32'h0000_0000);

        // RX: single byte push, pop, empty read
        uart_rx_data_out       = 8'h55;
        uart_rx_data_out_valid = 1'b1;
        #1;
        chk("rx_ready_empty", {31'h0, uart_rx_data_out_ready}, 32'h0000_0001);
        @(negedge clk);
        uart_rx_data_out_valid = 1'b0;
        #1;
`ifdef UART_RX_FIFO_EN
        chk("rx_ready_one", {31'h0, uart_rx_data_out_ready}, 32'h0000_0001);
`else
        chk("rx_ready_one", {31'h0, uart_rx_data_out_ready}, 32'h0000_0000);
`endif
        @(negedge clk);
        rd(8'h00, rd_val);
        chk("status_rx", rd_val, 32'h0000_0003);
        rd(8'h04, rd_val);
        chk("rx_pop_55", rd_val, 32'h0000_0055);
        rd(8'h00, rd_val);
        chk("status_after_pop", rd_val, 32'h0000_0001);
        rd(8'h04, rd_val);
        chk("rx_empty_read", rd_val, 32'h0000_0000);

`ifdef UART_RX_FIFO_EN
        // Fill the FIFO, then push and pop in the same cycle
        for (int i = 0; i < 8; i++) begin
            uart_rx_data_out       = 8'h10 + 8'(i);
            uart_rx_data_out_valid = 1'b1;
            @(negedge clk);
        end
        uart_rx_data_out = 8'h18;
        #1;
        chk("fifo_full_ready", {31'h0, uart_rx_data_out_ready}, 32'h0000_0000);
        mmio_en   = 1'b1;
        mmio_we   = 4'b0000;
        mmio_addr = 8'h04;
        #1;
        chk("fifo_pop_ready", {31'h0, uart_rx_data_out_ready}, 32'h0000_0001);
        @(negedge clk);
        mmio_en                = 1'b0;
        uart_rx_data_out_valid = 1'b0;
        chk("fifo_rd_0", mmio_rdata, 32'h0000_0010);
        for (int i = 1; i <= 8; i++) begin
            rd(8'h04, rd_val);
            chk("fifo_rd_seq", rd_val, 32'h0000_0010 + 32'(i));
        end
        rd(8'h04, rd_val);
        chk("fifo_drained", rd_val, 32'h0000_0000);
`else
        // Holding register full: second push stalls until a pop
        uart_rx_data_out       = 8'h66;
        uart_rx_data_out_valid = 1'b1;
        @(negedge clk);
        uart_rx_data_out = 8'h77;
        #1;
        chk("hold_full_ready", {31'h0, uart_rx_data_out_ready}, 32'h0000_0000);
        @(negedge clk);
        chk("hold_stall_ready", {31'h0, uart_rx_data_out_ready}, 32'h0000_0000);
        mmio_en   = 1'b1;
        mmio_we   = 4'b0000;
        mmio_addr = 8'h04;
        #1;
        chk("hold_pop_ready", {31'h0, uart_rx_data_out_ready}, 32'h0000_0001);
        @(negedge clk);
        mmio_en                = 1'b0;
        uart_rx_data_out_valid = 1'b0;
        chk("hold_rd_66", mmio_rdata, 32'h0000_0066);
        rd(8'h04, rd_val);
        chk("hold_rd_77", rd_val, 32'h0000_0077);
        rd(8'h04, rd_val);
        chk("hold_drained", rd_val, 32'h0000_0000);
`endif

        // Counters: clear beats a same-cycle retire, then counts from 1
        inst_retire = 1'b1;
        wr(8'h18, 32'hFFFF_FFFF, 4'b1111);
        rd(8'h14, rd_val);
        chk("inst_after_clr", rd_val, 32'h0000_0000);
        inst_retire = 1'b0;
        rd(8'h14, rd_val);
        chk("inst_count_1", rd_val, 32'h0000_0001);
        wr(8'h18, 32'h0000_0000, 4'b1000);
        rd(8'h10, rd_val);
        chk("cycle_after_clr", rd_val, 32'h0000_0000);
        rd(8'h10, rd_val);
        chk("cycle_count_1", rd_val, 32'h0000_0001);
        rd(8'h10, rd_val);
        chk("cycle_count_2", rd_val, 32'h0000_0002);

        // Cycle counter wrap from a preloaded value
        force dut.cycle_cnt_q = 32'hFFFF_FFFE;
        mmio_en   = 1'b1;
        mmio_we   = 4'b0000;
        mmio_addr = 8'h10;
        #1;
        release dut.cycle_cnt_q;
        @(negedge clk);
        chk("wrap_m2", mmio_rdata, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("wrap_m1", mmio_rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("wrap_zero", mmio_rdata, 32'h0000_0000);
        mmio_en = 1'b0;

        // Unmapped / write-only reads, write to read-only, data hold
        rd(8'h00, rd_val);
        rd(8'h0C, rd_val);
        chk("rd_unmapped_0c", rd_val, 32'h0000_0000);
        rd(8'h00, rd_val);
        rd(8'h08, rd_val);
        chk("rd_wo_08", rd_val, 32'h0000_0000);
        wr(8'h00, 32'hFFFF_FFFF, 4'b1111);
        chk("wr_ro_txvalid", {31'h0, uart_tx_data_in_valid}, 32'h0000_0000);
        rd(8'h00, rd_val);
        chk("wr_ro_status", rd_val, 32'h0000_0001);
        repeat (3) @(negedge clk);
        chk("rdata_held", mmio_rdata, 32'h0000_0001);

        // Reset while a TX byte is pending
        wr(8'h08, 32'h0000_005A, 4'b0001);
        chk("pend_before_rst", {31'h0, uart_tx_data_in_valid}, 32'h0000_0001);
        rst = 1'b0;
        #1;
        chk("midtx_rst_valid", {31'h0, uart_tx_data_in_valid}, 32'h0000_0000);
        chk("midtx_rst_byte",  {24'h0, uart_tx_data_in}, 32'h0000_0000);
        chk("midtx_rst_rdata", mmio_rdata, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(8'h00, rd_val);
        chk("midtx_status", rd_val, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
